fp16_mul_result_buffer: RTL and testbench
=========================================

// Module: fp16_mul_result_buffer
// PURPOSE
// - Downstream companion of the pipelined fp16_multiplier, which has a fixed 6-cycle latency, no stall and no valid.
// - Tracks issued operations through a valid shift register aligned to the multiplier latency.
// - Captures each result into a FIFO and presents it on a valid/ready stream.
// - Gates upstream issue by credit, so no result is ever dropped while the consumer backpressures.
// PARAMETERS
// - LATENCY  6  edges from multiplier input sample to the result being stable on mul_out.
// - DEPTH    8  FIFO entries; power of 2, >= 2.
// - AW       $clog2(DEPTH)  pointer width; derived, do not override.
// PORTS
// - clk        in   1      rising-edge clock shared with fp16_multiplier.
// - rst_n      in   1      asynchronous, active-low reset.
// - in_valid   in   1      producer presents a,b to the multiplier this cycle.
// - in_ready   out  1      credit available; op issued when in_valid & in_ready at an edge.
// - mul_out    in   16     fp16_multiplier.out.
// - out_valid  out  1      FIFO head valid.
// - out_ready  in   1      consumer accepts head.
// - out_data   out  16     FIFO head result (raw fp16 bits).
// - out_flags  out  4      {nan, inf, zero, subnormal} of out_data.
// - occupancy  out  AW+1   entries stored in the FIFO (excludes in-flight).
// BEHAVIOUR
// - Reset: vpipe=0, FIFO empty, reserved=0, out_valid=0, out_data=0, out_flags=0, occupancy=0, in_ready=1.
// - Issue: acc = in_valid & in_ready. The producer drives a,b unconditionally; the multiplier samples them every
//   edge, and this block ignores non-accepted slots.
// - vpipe[LATENCY-1:0]: at each edge, vpipe <= {vpipe[LATENCY-2:0], acc}.
// - Write: wr = vpipe[LATENCY-1]. At that edge, mul_out is pushed.
// - Latency: an op accepted at edge k is written at edge k+LATENCY; out_valid is asserted from the cycle after it.
// - Pop: rd = out_valid & out_ready. out_data/out_flags are the head entry, first-word registered, not combinational
//   from mul_out.
// - Credit: reserved (AW+1 bits) = FIFO entries + in-flight ops.
//   - +1 on acc, -1 on rd; both in the same cycle -> unchanged.
//   - in_ready = (reserved < DEPTH); combinational from the register only, not from out_ready.
// - Full: reserved==DEPTH deasserts in_ready even if rd occurs that cycle; in_ready re-asserts the next cycle.
// - Overflow is impossible by construction. Simultaneous wr and rd at any level: occupancy unchanged, order preserved.
// - Pointers wrap modulo DEPTH. Empty when occupancy==0 (out_valid=0); full when occupancy==DEPTH.
// - Throughput: 1 op/cycle sustained while out_ready=1.
// - Reset mid-operation: in-flight ops and FIFO contents are discarded.
//   - The multiplier is unreset, so its pipeline keeps stale data; vpipe=0 guarantees this is never written.
// - Flag rules on the 16-bit word w, with e=w[14:10], f=w[9:0]:
//   - nan = (e==1F) & (f!=0);  inf = (e==1F) & (f==0);  zero = (e==0) & (f==0);  subnormal = (e==0) & (f!=0).
// CONFIGURATION
// - FP16_MUL_BUF_FLAGS_EN defined:
//   - flags are computed from mul_out at write time and stored alongside it; FIFO width is 20.
// - Not defined:
//   - no flag logic or storage; FIFO width is 16; out_flags is tied to 4'h0.
// - out_data and timing are identical in both builds.
// TESTING
// - 3C00*4000 (1.0*2.0), accepted at edge k:
//   - out_valid rises after edge k+6 with out_data=4000, flags=0000.
// - 7C00*0000 (inf*0):
//   - out_data=7E00; flags=1000 with _EN defined, 0000 without.
// - out_ready=0, in_valid=1 for 12 cycles:
//   - exactly 8 ops accepted; in_ready=0 after the 8th; occupancy reaches 8.
//   - Then out_ready=1 drains 8 entries in issue order.
// - Full, with rd and acc requested in the same cycle:
//   - no accept that cycle; in_ready=1 the next cycle; one accept then; no loss or duplication.
// - 16 back-to-back ops with out_ready=1:
//   - one result per cycle; output sequence matches the reference model in order; occupancy <= 1.
// - rst_n pulsed low with 3 ops in flight and 2 stored:
//   - all outputs take their reset values asynchronously.
//   - No out_valid for 7 cycles after release without new issue.

Source files
------------

// File: rtl/fp16_mul_result_buffer.sv
// Result buffer behind the fixed-latency fp16_multiplier: tracks issued ops, captures results, credit-gates issue.
// Build macro FP16_MUL_BUF_FLAGS_EN stores {nan, inf, zero, subnormal} flags alongside each stored result.
module fp16_mul_result_buffer #(
    parameter int LATENCY = 6,
    parameter int DEPTH   = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   mul_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic [3:0]    out_flags,
    output logic [AW:0]   occupancy
);

`ifdef FP16_MUL_BUF_FLAGS_EN
    localparam int FW = 20;
`else
    localparam int FW = 16;
`endif
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [LATENCY-1:0] vpipe;
    logic [AW:0]        reserved;
    logic [AW:0]        count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [FW-1:0]      mem [DEPTH];
    logic [FW-1:0]      wr_word;
    logic [FW-1:0]      head;
    logic               acc;
    logic               wr;
    logic               rd;

    // Credit covers stored plus in-flight results, so a write never finds the FIFO full.
    assign in_ready  = reserved < DEPTH_C;
    assign acc       = in_valid & in_ready;
    assign wr        = vpipe[LATENCY-1];
    assign out_valid = count != '0;
    assign rd        = out_valid & out_ready;
    assign occupancy = count;
    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[15:0] : 16'h0000;

`ifdef FP16_MUL_BUF_FLAGS_EN
    logic [4:0] w_exp;
    logic [9:0] w_frac;

    assign w_exp  = mul_out[14:10];
    assign w_frac = mul_out[9:0];

    always_comb begin
        wr_word        = '0;
        wr_word[15:0]  = mul_out;
        wr_word[19]    = (w_exp == 5'h1F) && (w_frac != 10'h0);
        wr_word[18]    = (w_exp == 5'h1F) && (w_frac == 10'h0);
        wr_word[17]    = (w_exp == 5'h00) && (w_frac == 10'h0);
        wr_word[16]    = (w_exp == 5'h00) && (w_frac != 10'h0);
    end

    assign out_flags = out_valid ? head[19:16] : 4'h0;
`else
    assign wr_word   = mul_out;
    assign out_flags = 4'h0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe    <= '0;
            reserved <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            vpipe <= {vpipe[LATENCY-2:0], acc};

            if (acc && !rd) begin
                reserved <= reserved + CNT_ONE;
            end else if (!acc && rd) begin
                reserved <= reserved - CNT_ONE;
            end

            if (wr && !rd) begin
                count <= count + CNT_ONE;
            end else if (!wr && rd) begin
                count <= count - CNT_ONE;
            end

            if (wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is not reset; out_data/out_flags are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_word;
        end
    end

endmodule

// File: tb/tb_fp16_mul_result_buffer.sv
// Self-checking bench for fp16_mul_result_buffer with a behavioural 6-stage fp16_multiplier stand-in.
// Expected flags follow the FP16_MUL_BUF_FLAGS_EN build macro.
module tb_fp16_mul_result_buffer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef FP16_MUL_BUF_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [15:0]   a = 16'h0;
    logic [15:0]   b = 16'h0;
    logic [15:0]   mul_out;
    logic [15:0]   out_data;
    logic [3:0]    out_flags;
    logic [AW:0]   occupancy;
    logic [15:0]   mstage [6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int max_occ = 0;
    logic [15:0] exp_q [$];
    logic [15:0] got_d [$];
    logic [3:0]  got_f [$];
    int          pop_cyc [$];

    fp16_mul_result_buffer #(.LATENCY(6), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_out   (mul_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Truncating fp16 multiply: specials per IEEE, finite values via integer mantissa product.
    function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
        logic        s;
        logic [21:0] p;
        int          ex, ey, e;
        logic        nx, ny, ix, iy, zx, zy;
        s  = x[15] ^ y[15];
        nx = (x[14:10] == 5'h1F) && (x[9:0] != 0);
        ny = (y[14:10] == 5'h1F) && (y[9:0] != 0);
        ix = (x[14:10] == 5'h1F) && (x[9:0] == 0);
        iy = (y[14:10] == 5'h1F) && (y[9:0] == 0);
        zx = (x[14:0] == 0);
        zy = (y[14:0] == 0);
        if (nx || ny || (ix && zy) || (zx && iy)) return 16'h7E00;
        if (ix || iy) return {s, 5'h1F, 10'h0};
        if (zx || zy) return {s, 15'h0};
        ex = (x[14:10] == 0) ? 1 : int'(x[14:10]);
        ey = (y[14:10] == 0) ? 1 : int'(y[14:10]);
        p  = 22'({(x[14:10] != 0), x[9:0]}) * 22'({(y[14:10] != 0), y[9:0]});
        e  = ex + ey - 15;
        if (p[21]) begin
            p = p >> 1;
            e = e + 1;
        end
        while (p != 0 && !p[20] && e > 1) begin
            p = p << 1;
            e = e - 1;
        end
        if (e < 1) begin
            p = (1 - e > 21) ? 22'h0 : (p >> (1 - e));
            e = 1;
        end
        if (e >= 31) return {s, 5'h1F, 10'h0};
        if (p[20]) return {s, 5'(e), p[19:10]};
        return {s, 5'h0, p[19:10]};
    endfunction

    function automatic logic [3:0] exp_flags(input logic [15:0] w);
        logic [3:0] fl;
        fl = {(w[14:10] == 5'h1F) && (w[9:0] != 0), (w[14:10] == 5'h1F) && (w[9:0] == 0),
              (w[14:10] == 5'h00) && (w[9:0] == 0), (w[14:10] == 5'h00) && (w[9:0] != 0)};
        return FLAGS_ON ? fl : 4'h0;
    endfunction

    function automatic logic [15:0] rand_fp();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h7C00;
            2: return 16'h7E01;
            3: return 16'h0003;
            default: return 16'($urandom);
        endcase
    endfunction

    // Unreset multiplier pipeline: sampled at edge k, stable on mul_out after edge k+5.
    always @(posedge clk) begin
        mstage[0] <= fp16_mul(a, b);
        for (int i = 1; i < 6; i++) mstage[i] <= mstage[i-1];
        cyc <= cyc + 1;
    end
    assign mul_out = mstage[5];

    // Handshakes are recorded mid-cycle, from the values the next edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(fp16_mul(a, b));
                acc_cnt = acc_cnt + 1;
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_f.push_back(out_flags);
                pop_cyc.push_back(cyc);
            end
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        got_d.delete();
        got_f.delete();
        pop_cyc.delete();
        max_occ = 0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #2;
            if (!out_valid && got_d.size() >= exp_q.size()) break;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h f=%b exp v=0 d=0000 f=0000", out_valid, out_data, out_flags);
        end
        checks++;
        if (occupancy !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_credit got occ=%0d rdy=%b exp occ=0 rdy=1", occupancy, in_ready);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency(input logic [15:0] xa, input logic [15:0] xb,
                                input logic [15:0] exp_d, input logic [3:0] exp_f);
        clear_sb();
        @(posedge clk); #2;
        a = xa; b = xb; in_valid = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            checks++;
            if (out_valid !== (i == 7)) begin
                errors++;
                $display("FAIL latency_valid edge+%0d got %b exp %b", i - 1, out_valid, (i == 7));
            end
        end
        checks++;
        if (out_data !== exp_d || out_flags !== exp_f) begin
            errors++;
            $display("FAIL latency_data got %h/%b exp %h/%b", out_data, out_flags, exp_d, exp_f);
        end
        drain();
        checks++;
        if (got_d.size() != 1 || occupancy !== 4'd0) begin
            errors++;
            $display("FAIL latency_pop got n=%0d occ=%0d exp n=1 occ=0", got_d.size(), occupancy);
        end
    endtask

    task automatic test_fill();
        int acc0;
        clear_sb();
        acc0 = acc_cnt;
        @(posedge clk); #2;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            a = rand_fp();
            b = rand_fp();
            @(posedge clk); #2;
            if (i == 7 || i == 8) begin
                checks++;
                if (in_ready !== (i == 7)) begin
                    errors++;
                    $display("FAIL fill_ready after op %0d got %b exp %b", i, in_ready, (i == 7));
                end
            end
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        checks++;
        if (acc_cnt - acc0 != 8 || occupancy !== 4'd8 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_level got acc=%0d occ=%0d v=%b exp acc=8 occ=8 v=1", acc_cnt - acc0, occupancy, out_valid);
        end
        drain();
        checks++;
        if (got_d.size() != 8) begin
            errors++;
            $display("FAIL fill_count got %0d exp 8", got_d.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_f[i] !== exp_flags(exp_q[i])) begin
                errors++;
                $display("FAIL fill_data[%0d] got %h/%b exp %h/%b", i, got_d[i], got_f[i], exp_q[i], exp_flags(exp_q[i]));
            end
        end
    endtask

    task automatic test_full_simul();
        int acc0;
        clear_sb();
        acc0 = acc_cnt;
        @(posedge clk); #2;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = rand_fp();
            b = rand_fp();
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        a = 16'h3C00; b = 16'h3C00;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_before got %b exp 0", in_ready);
        end
        @(posedge clk); #2;
        checks++;
        if (acc_cnt - acc0 != 8 || occupancy !== 4'd7 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_simul got acc=%0d occ=%0d rdy=%b exp acc=8 occ=7 rdy=1", acc_cnt - acc0, occupancy, in_ready);
        end
        out_ready = 1'b0;
        a = 16'h4200; b = 16'h4400;
        @(posedge clk); #2;
        checks++;
        if (acc_cnt - acc0 != 9 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_reaccept got acc=%0d rdy=%b exp acc=9 rdy=0", acc_cnt - acc0, in_ready);
        end
        drain();
        checks++;
        if (got_d.size() != 9) begin
            errors++;
            $display("FAIL full_count got %0d exp 9", got_d.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_f[i] !== exp_flags(exp_q[i])) begin
                errors++;
                $display("FAIL full_data[%0d] got %h/%b exp %h/%b", i, got_d[i], got_f[i], exp_q[i], exp_flags(exp_q[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc0;
        clear_sb();
        acc0 = acc_cnt;
        @(posedge clk); #2;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = rand_fp();
            b = rand_fp();
            @(posedge clk); #2;
        end
        drain();
        checks++;
        if (acc_cnt - acc0 != 16 || got_d.size() != 16 || max_occ > 1) begin
            errors++;
            $display("FAIL b2b_counts got acc=%0d pops=%0d maxocc=%0d exp 16/16/<=1", acc_cnt - acc0, got_d.size(), max_occ);
        end
        checks++;
        if (pop_cyc.size() != 16 || pop_cyc[pop_cyc.size()-1] - pop_cyc[0] != 15) begin
            errors++;
            $display("FAIL b2b_rate got pops=%0d span=%0d exp pops=16 span=15", pop_cyc.size(),
                     (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size()-1] - pop_cyc[0] : -1);
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_f[i] !== exp_flags(exp_q[i])) begin
                errors++;
                $display("FAIL b2b_data[%0d] got %h/%b exp %h/%b", i, got_d[i], got_f[i], exp_q[i], exp_flags(exp_q[i]));
            end
        end
    endtask

    task automatic test_random();
        clear_sb();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            a = rand_fp();
            b = rand_fp();
        end
        drain();
        checks++;
        if (got_d.size() != exp_q.size() || max_occ > DEPTH || exp_q.size() == 0) begin
            errors++;
            $display("FAIL rand_counts got pops=%0d exp %0d maxocc=%0d", got_d.size(), exp_q.size(), max_occ);
        end
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_f[i] !== exp_flags(exp_q[i])) begin
                errors++;
                $display("FAIL rand_data[%0d] got %h/%b exp %h/%b", i, got_d[i], got_f[i], exp_q[i], exp_flags(exp_q[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        clear_sb();
        @(posedge clk); #2;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 16'h3C00; b = 16'h4000;
        repeat (2) @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        checks++;
        if (occupancy !== 4'd2) begin
            errors++;
            $display("FAIL rstmid_setup got occ=%0d exp 2", occupancy);
        end
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_flags !== 4'h0 || occupancy !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async got v=%b d=%h f=%b occ=%0d rdy=%b exp 0/0000/0000/0/1",
                     out_valid, out_data, out_flags, occupancy, in_ready);
        end
        clear_sb();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #2;
            if (out_valid !== 1'b0 || occupancy !== 4'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rstmid_stale got stale out_valid=1 after release exp 0");
        end
        in_valid = 1'b1;
        a = 16'hC000; b = 16'h3800;
        @(posedge clk); #2;
        drain();
        checks++;
        if (got_d.size() != 1 || exp_q.size() != 1 || got_d[0] !== 16'hBC00) begin
            errors++;
            $display("FAIL rstmid_resume got n=%0d d=%h exp n=1 d=bc00", got_d.size(),
                     (got_d.size() > 0) ? got_d[0] : 16'hxxxx);
        end
    endtask

    initial begin
        test_reset();
        test_latency(16'h3C00, 16'h4000, 16'h4000, 4'b0000);
        test_latency(16'h7C00, 16'h0000, 16'h7E00, FLAGS_ON ? 4'b1000 : 4'b0000);
        test_fill();
        test_full_simul();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
